// File: rtl/booth16_seq_mult_ctrl.sv
// Signed radix-16 Booth multiplier: one digit per cycle into a carry-save accumulator, then one carry-propagate add.
// Latency NDIG+2 edges from accept to out_valid; single transaction in flight, in_ready stays low until the product is taken.
module booth16_seq_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand_in,
   input  logic [WIDTH-1:0]     multiplier_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product_out,
   output logic                 busy
);
   localparam int NDIG = WIDTH / 4;
   localparam int AW   = 2 * WIDTH + 4;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("booth16_seq_mult_ctrl: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [AW-1:0]        r_sum;
   logic [AW-1:0]        r_carry;
   logic [CW-1:0]        r_cnt;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;
   logic [2*WIDTH-1:0]   r_product;

   logic [WIDTH:0]       w_bx;
   logic [4:0]           w_grp;
   logic signed [4:0]    w_dig;
   logic [AW-1:0]        w_a_x;
   logic [AW-1:0]        w_dig_x;
   logic [AW-1:0]        w_pp;
   logic [AW-1:0]        w_pp_sh;
   logic [AW-1:0]        w_carry_sh;
   logic [AW-1:0]        w_csa_sum;
   logic [AW-1:0]        w_csa_carry;
   logic [2*WIDTH-1:0]   w_resolved;
   logic                 w_last_dig;

   // B with an implicit zero below bit 0, so each 5-bit window is {B[4i+3:4i], B[4i-1]}.
   assign w_bx  = {r_b, 1'b0};
   assign w_grp = 5'(w_bx >> {r_cnt, 2'b00});
   assign w_dig = $signed({w_grp[4], w_grp[4:1]}) + $signed({4'b0000, w_grp[0]});

   assign w_a_x   = {{(AW-WIDTH){r_a[WIDTH-1]}}, r_a};
   assign w_dig_x = {{(AW-5){w_dig[4]}}, w_dig};
   assign w_pp    = w_a_x * w_dig_x;
   assign w_pp_sh = w_pp << {r_cnt, 2'b00};

   // Carry is stored unshifted; its weight is applied both when compressing and when resolving.
   assign w_carry_sh  = r_carry << 1;
   assign w_csa_sum   = r_sum ^ w_carry_sh ^ w_pp_sh;
   assign w_csa_carry = (r_sum & w_carry_sh) | (r_sum & w_pp_sh) | (w_carry_sh & w_pp_sh);
   assign w_resolved  = r_sum[2*WIDTH-1:0] + w_carry_sh[2*WIDTH-1:0];
   assign w_last_dig  = (r_cnt == CW'(NDIG - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_product   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= multiplicand_in;
                  r_b        <= multiplier_in;
                  r_sum      <= '0;
                  r_carry    <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ACCUM;
               end
            end
            ACCUM: begin
               r_sum   <= w_csa_sum;
               r_carry <= w_csa_carry;
               if (w_last_dig) begin
                  r_cnt   <= '0;
                  r_state <= RESOLVE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESOLVE: begin
               r_product   <= w_resolved;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign product_out = r_product;
   assign busy        = r_busy;

endmodule

// File: tb/tb_booth16_seq_mult_ctrl.sv
// Bench for booth16_seq_mult_ctrl at WIDTH=8 (directed) and WIDTH=16 (reset abort, corners, random with stalls).
module tb_booth16_seq_mult_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   logic        rst8 = 1'b1, in_valid8 = 1'b0, out_ready8 = 1'b1;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        in_ready8, out_valid8, busy8;
   logic [15:0] prod8;

   logic        rst16 = 1'b1, in_valid16 = 1'b0, out_ready16 = 1'b1;
   logic [15:0] a16 = '0, b16 = '0;
   logic        in_ready16, out_valid16, busy16;
   logic [31:0] prod16;

   booth16_seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
      .multiplicand_in(a8), .multiplier_in(b8), .out_valid(out_valid8),
      .out_ready(out_ready8), .product_out(prod8), .busy(busy8)
   );

   booth16_seq_mult_ctrl #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
      .multiplicand_in(a16), .multiplier_in(b16), .out_valid(out_valid16),
      .out_ready(out_ready16), .product_out(prod16), .busy(busy16)
   );

   logic [15:0] q8[$];
   logic [31:0] q16[$];
   int          acc8_hist[$];
   int          last_acc8 = 0, last_acc16 = 0, n_acc8 = 0, n_acc16 = 0;
   logic        prev_ov8 = 1'b0, prev_stall8 = 1'b0, prev_ov16 = 1'b0, prev_stall16 = 1'b0;
   logic [15:0] prev_prod8 = '0;
   logic [31:0] prev_prod16 = '0;
   bit          rand_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitors: latency, scoreboard pop on handshake, hold under backpressure, no unexpected output.
   always @(negedge clk) begin
      if (!rst8) begin
         if (in_valid8 && in_ready8) begin
            n_acc8++;
            last_acc8 = cyc;
            acc8_hist.push_back(cyc);
         end
         if (prev_stall8) begin
            chk("hold_valid8", out_valid8, 1);
            chk("hold_prod8", prod8, prev_prod8);
         end
         if (out_valid8 && !prev_ov8) chk("latency8", cyc - last_acc8, 4);
         if (out_valid8) begin
            chk("spurious8", q8.size() != 0, 1);
            if (out_ready8 && q8.size() != 0) chk("prod8", prod8, q8.pop_front());
         end
      end
      prev_ov8    = out_valid8 && !rst8;
      prev_stall8 = out_valid8 && !out_ready8 && !rst8;
      prev_prod8  = prod8;
   end

   always @(negedge clk) begin
      if (!rst16) begin
         if (in_valid16 && in_ready16) begin
            n_acc16++;
            last_acc16 = cyc;
         end
         if (prev_stall16) begin
            chk("hold_valid16", out_valid16, 1);
            chk("hold_prod16", prod16, prev_prod16);
         end
         if (out_valid16 && !prev_ov16) chk("latency16", cyc - last_acc16, 6);
         if (out_valid16) begin
            chk("spurious16", q16.size() != 0, 1);
            if (out_ready16 && q16.size() != 0) chk("prod16", prod16, q16.pop_front());
         end
      end
      prev_ov16    = out_valid16 && !rst16;
      prev_stall16 = out_valid16 && !out_ready16 && !rst16;
      prev_prod16  = prod16;
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit keep);
      bit got = 1'b0;
      a8 = a; b8 = b; in_valid8 = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (in_ready8) begin
            got = 1'b1;
            q8.push_back(exp);
         end
      end
      chk("accept8", got, 1);
      @(posedge clk); #1;
      if (!keep) in_valid8 = 1'b0;
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b);
      bit got = 1'b0;
      logic signed [31:0] e;
      e = $signed(a) * $signed(b);
      a16 = a; b16 = b; in_valid16 = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (in_ready16) begin
            got = 1'b1;
            q16.push_back(e);
         end
      end
      chk("accept16", got, 1);
      @(posedge clk); #1;
      in_valid16 = 1'b0;
   endtask

   task automatic wait_idle8();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (q8.size() == 0 && !out_valid8) ok = 1'b1;
      end
      chk("drain8", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle16();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (q16.size() == 0 && !out_valid16) ok = 1'b1;
      end
      chk("drain16", ok, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lo;
      int acc_before;
      logic [15:0] corners [6];
      corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8001, 16'h8000};

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready8", in_ready8, 1);
      chk("rst_out_valid8", out_valid8, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_prod8", prod8, 0);
      chk("rst_in_ready16", in_ready16, 1);
      chk("rst_busy16", busy16, 0);
      chk("rst_prod16", prod16, 0);
      @(posedge clk); #1;
      rst8 = 1'b0; rst16 = 1'b0;
      @(posedge clk); #1;

      // 7 x -3, with in_ready low window
      op8(8'd7, 8'hFD, 16'hFFEB, 1'b0);
      lo = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready8) break;
         lo++;
      end
      chk("in_ready_low8", lo, 4);
      @(posedge clk); #1;
      wait_idle8();

      // Corner operands
      op8(8'h80, 8'h80, 16'h4000, 1'b0); wait_idle8();
      op8(8'h7F, 8'h7F, 16'h3F01, 1'b0); wait_idle8();
      op8(8'h80, 8'h78, 16'hC400, 1'b0); wait_idle8();

      // Backpressure with operand/in_valid churn
      out_ready8 = 1'b0;
      op8(8'd5, 8'd6, 16'd30, 1'b0);
      lo = 0;
      for (int i = 0; i < 20 && !out_valid8; i++) begin
         @(negedge clk);
         lo = i;
      end
      chk("bp_out_valid8", out_valid8, 1);
      acc_before = n_acc8;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = ~in_valid8;
         @(negedge clk);
         chk("bp_in_ready8", in_ready8, 0);
         chk("bp_prod8", prod8, 16'd30);
      end
      chk("bp_no_accept8", n_acc8, acc_before);
      @(posedge clk); #1;
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release_valid8", out_valid8, 0);
      chk("bp_release_ready8", in_ready8, 1);
      @(posedge clk); #1;

      // Back-to-back with in_valid held
      acc8_hist.delete();
      op8(8'd3, 8'd4, 16'd12, 1'b1);
      op8(8'd0, 8'hFF, 16'd0, 1'b1);
      op8(8'hFF, 8'hFF, 16'd1, 1'b0);
      wait_idle8();
      chk("b2b_count8", acc8_hist.size(), 3);
      if (acc8_hist.size() == 3) begin
         chk("b2b_gap0", acc8_hist[1] - acc8_hist[0], 5);
         chk("b2b_gap1", acc8_hist[2] - acc8_hist[1], 5);
      end

      // WIDTH=16: one op, then abort mid-ACCUM with in_valid asserted during rst
      op16(16'd1234, 16'hFFF0);
      wait_idle16();
      chk("pre_rst_prod16", prod16, 32'hFFFF_B2E0);
      op16(16'h7FFF, 16'h7FFF);
      @(posedge clk); #1;
      rst16 = 1'b1; in_valid16 = 1'b1; a16 = 16'd9; b16 = 16'd9;
      @(posedge clk); #1;
      rst16 = 1'b0; in_valid16 = 1'b0;
      q16.delete();
      @(negedge clk);
      chk("abort_in_ready16", in_ready16, 1);
      chk("abort_busy16", busy16, 0);
      chk("abort_out_valid16", out_valid16, 0);
      chk("abort_prod16", prod16, 0);
      for (int i = 0; i < 15; i++) @(negedge clk);
      chk("abort_quiet16", busy16, 0);
      @(posedge clk); #1;
      op16(16'hFF85, 16'd300);
      wait_idle16();

      // Corners plus random pairs under random out_ready stalls
      fork
         begin
            foreach (corners[i]) foreach (corners[j]) op16(corners[i], corners[j]);
            for (int k = 0; k < 1000; k++) op16(16'($urandom), 16'($urandom));
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready16 = ($urandom_range(0, 3) != 0);
            end
            out_ready16 = 1'b1;
         end
      join
      wait_idle16();
      chk("accepts16", n_acc16, 1036 + 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
